// File: rtl/mem_bus_arbiter.sv
// Two-port 16-bit word arbiter onto an 8-bit external memory bus.
// Each word is two byte cycles (high byte first); all bus outputs are registered.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        req0,
  input  logic        rw0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  output logic [15:0] rdata0,
  output logic        done0,
  input  logic        req1,
  input  logic        rw1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic [15:0] rdata1,
  output logic        done1,
  output logic [14:0] mem_addr,
  output logic        a15,
  output logic        memen,
  output logic        dbin,
  output logic        we,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        mem_doe,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

  typedef struct packed {
    logic        rw;
    logic [14:0] addr;
    logic [15:0] wdata;
  } slot_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        byte_sel_q, byte_sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend0_q, pend0_d, pend1_q, pend1_d;
  slot_t       slot0_q, slot0_d, slot1_q, slot1_d, cur_q, cur_d;
  logic        memen_q, memen_d, dbin_q, dbin_d, we_q, we_d;
  logic        doe_q, doe_d, a15_q, a15_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        busy_q, busy_d, grant_q, grant_d;
  logic        clr0, clr1, gnt;
  slot_t       sel_slot;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    memen_d    = memen_q;
    dbin_d     = dbin_q;
    we_d       = we_q;
    doe_d      = doe_q;
    a15_d      = a15_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = busy_q;
    grant_d    = grant_q;
    clr0       = 1'b0;
    clr1       = 1'b0;
    gnt        = grant_q;
    sel_slot   = slot0_q;

    unique case (state_q)
      S_IDLE: begin
        if (pend0_q || pend1_q) begin
          // On a tie the port that was not served last wins.
          gnt        = (pend0_q && pend1_q) ? ~grant_q : pend1_q;
          sel_slot   = gnt ? slot1_q : slot0_q;
          clr0       = ~gnt;
          clr1       = gnt;
          grant_d    = gnt;
          cur_d      = sel_slot;
          busy_d     = 1'b1;
          byte_sel_d = 1'b0;
          state_d    = S_SETUP;
          memen_d    = 1'b0;
          a15_d      = 1'b0;
          mem_addr_d = sel_slot.addr;
          doe_d      = ~sel_slot.rw;
          if (!sel_slot.rw) mem_dout_d = sel_slot.wdata[15:8];
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = 4'd0;
        if (cur_q.rw) dbin_d = 1'b1;
        else          we_d   = 1'b0;
      end
      S_STROBE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_HOLD;
          dbin_d  = 1'b0;
          we_d    = 1'b1;
          if (cur_q.rw) begin
            if (!grant_q) begin
              if (!byte_sel_q) rdata0_d[15:8] = mem_din;
              else             rdata0_d[7:0]  = mem_din;
            end else begin
              if (!byte_sel_q) rdata1_d[15:8] = mem_din;
              else             rdata1_d[7:0]  = mem_din;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (!byte_sel_q) begin
          byte_sel_d = 1'b1;
          state_d    = S_SETUP;
          a15_d      = 1'b1;
          if (!cur_q.rw) mem_dout_d = cur_q.wdata[7:0];
        end else begin
          state_d = S_DONE;
          memen_d = 1'b1;
          doe_d   = 1'b0;
          busy_d  = 1'b0;
          done0_d = ~grant_q;
          done1_d = grant_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new request on the same edge outranks the clear from being granted.
    pend0_d = req0 | (pend0_q & ~clr0);
    pend1_d = req1 | (pend1_q & ~clr1);
    slot0_d = req0 ? slot_t'{rw0, addr0[15:1], wdata0} : slot0_q;
    slot1_d = req1 ? slot_t'{rw1, addr1[15:1], wdata1} : slot1_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_sel_q <= 1'b0;
      cnt_q      <= 4'd0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      cur_q      <= '0;
      memen_q    <= 1'b1;
      dbin_q     <= 1'b0;
      we_q       <= 1'b1;
      doe_q      <= 1'b0;
      a15_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      cnt_q      <= cnt_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      cur_q      <= cur_d;
      memen_q    <= memen_d;
      dbin_q     <= dbin_d;
      we_q       <= we_d;
      doe_q      <= doe_d;
      a15_q      <= a15_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign a15      = a15_q;
  assign memen    = memen_q;
  assign dbin     = dbin_q;
  assign we       = we_q;
  assign mem_dout = mem_dout_q;
  assign mem_doe  = doe_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at WAIT_CYCLES=3, one at 1.
// Per-cycle bus activity is captured into bit traces and compared to hand-derived masks.
module tb_mem_bus_arbiter;

  logic clk100 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk100 = ~clk100;

  logic        req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
  logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic [15:0] rdata0, rdata1;
  logic        done0, done1;
  logic [14:0] mem_addr;
  logic        a15, memen, dbin, we, mem_doe, busy, grant;
  logic [7:0]  mem_din, mem_dout;

  logic        req0_w1 = 0, rw0_w1 = 0;
  logic [15:0] addr0_w1 = 0;
  logic [15:0] rdata0_w1, rdata1_w1;
  logic        done0_w1, done1_w1;
  logic [14:0] mem_addr_w1;
  logic        a15_w1, memen_w1, dbin_w1, we_w1, doe_w1, busy_w1, grant_w1;
  logic [7:0]  mem_din_w1, mem_dout_w1;

  logic [7:0]  mem_hi = 8'h00, mem_lo = 8'h00;
  assign mem_din    = a15    ? mem_lo : mem_hi;
  assign mem_din_w1 = a15_w1 ? mem_lo : mem_hi;

  mem_bus_arbiter #(.WAIT_CYCLES(3)) dut (
    .clk100(clk100), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .done1(done1),
    .mem_addr(mem_addr), .a15(a15), .memen(memen), .dbin(dbin), .we(we),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_doe(mem_doe), .busy(busy), .grant(grant)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk100(clk100), .reset(reset),
    .req0(req0_w1), .rw0(rw0_w1), .addr0(addr0_w1), .wdata0(16'h0000), .rdata0(rdata0_w1), .done0(done0_w1),
    .req1(1'b0), .rw1(1'b0), .addr1(16'h0000), .wdata1(16'h0000), .rdata1(rdata1_w1), .done1(done1_w1),
    .mem_addr(mem_addr_w1), .a15(a15_w1), .memen(memen_w1), .dbin(dbin_w1), .we(we_w1),
    .mem_din(mem_din_w1), .mem_dout(mem_dout_w1), .mem_doe(doe_w1), .busy(busy_w1), .grant(grant_w1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] memen_tr, dbin_tr, we_tr, doe_tr, done0_tr, done1_tr, busy_tr, a15_tr, grant_tr;
  logic [14:0] addr_tr [32];
  logic [7:0]  dout_tr [32];

  // Cycle c is the period after the c-th rising edge following the request edge.
  task automatic run_trace(input bit w1, input int inj_cycle, input logic [15:0] inj_addr);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk100);
      if (c == 0) begin
        req0 = 1'b0; req1 = 1'b0; req0_w1 = 1'b0;
      end
      if (c == inj_cycle + 1) req1 = 1'b0;
      memen_tr[c] = w1 ? memen_w1 : memen;
      dbin_tr[c]  = w1 ? dbin_w1  : dbin;
      we_tr[c]    = w1 ? we_w1    : we;
      doe_tr[c]   = w1 ? doe_w1   : mem_doe;
      done0_tr[c] = w1 ? done0_w1 : done0;
      done1_tr[c] = w1 ? done1_w1 : done1;
      busy_tr[c]  = w1 ? busy_w1  : busy;
      a15_tr[c]   = w1 ? a15_w1   : a15;
      grant_tr[c] = w1 ? grant_w1 : grant;
      addr_tr[c]  = w1 ? mem_addr_w1 : mem_addr;
      dout_tr[c]  = w1 ? mem_dout_w1 : mem_dout;
      if (c == inj_cycle) begin
        req1 = 1'b1; rw1 = 1'b1; addr1 = inj_addr;
      end
    end
  endtask

  initial begin
    // Reset values
    @(negedge clk100);
    @(negedge clk100);
    check("rst_memen", memen, 1);
    check("rst_we", we, 1);
    check("rst_dbin", dbin, 0);
    check("rst_doe", mem_doe, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 1);
    check("rst_done0", done0, 0);
    check("rst_rdata0", rdata0, 0);
    reset = 1'b0;
    @(negedge clk100);

    // Read on port 0, WAIT_CYCLES=3
    req0 = 1; rw0 = 1; addr0 = 16'hF000; mem_hi = 8'hAA; mem_lo = 8'h55;
    run_trace(0, -1, 16'h0);
    check("rd_done0", done0_tr, 32'h0000_0800);
    check("rd_memen", memen_tr, 32'hFFFF_F801);
    check("rd_dbin", dbin_tr, 32'h0000_039C);
    check("rd_we", we_tr, 32'hFFFF_FFFF);
    check("rd_busy", busy_tr, 32'h0000_07FE);
    check("rd_a15", a15_tr & 32'h0000_07FE, 32'h0000_07C0);
    check("rd_addr", addr_tr[1], 15'h7800);
    check("rd_grant", grant_tr[1], 0);
    check("rd_rdata0", rdata0, 16'hAA55);

    // Write on port 0
    req0 = 1; rw0 = 0; addr0 = 16'h0246; wdata0 = 16'h83E0;
    run_trace(0, -1, 16'h0);
    check("wr_done0", done0_tr, 32'h0000_0800);
    check("wr_we", we_tr, 32'hFFFF_FC63);
    check("wr_doe", doe_tr, 32'h0000_07FE);
    check("wr_dbin", dbin_tr, 32'h0);
    check("wr_dout_hi", {a15_tr[2], dout_tr[2]}, {1'b0, 8'h83});
    check("wr_dout_lo", {a15_tr[7], dout_tr[7]}, {1'b1, 8'hE0});
    check("wr_rdata0_hold", rdata0, 16'hAA55);

    // Tie straight after reset: port 0 first, then port 1
    reset = 1'b1;
    @(negedge clk100);
    reset = 1'b0;
    @(negedge clk100);
    req0 = 1; rw0 = 1; addr0 = 16'h1234;
    req1 = 1; rw1 = 0; addr1 = 16'hABCD; wdata1 = 16'h5AA5;
    mem_hi = 8'h0F; mem_lo = 8'hF0;
    run_trace(0, -1, 16'h0);
    check("tie_done0", done0_tr, 32'h0000_0800);
    check("tie_done1", done1_tr, 32'h0080_0000);
    check("tie_busy", busy_tr, 32'h007F_E7FE);
    check("tie_memen", memen_tr, 32'hFF80_1801);
    check("tie_grant_first", grant_tr[1], 0);
    check("tie_grant_second", grant_tr[13], 1);
    check("tie_addr0", addr_tr[1], 15'h091A);
    check("tie_addr1", addr_tr[13], 15'h55E6);
    check("tie_doe", doe_tr, 32'h007F_E000);
    check("tie_dout_hi", dout_tr[14], 8'h5A);
    check("tie_dout_lo", dout_tr[19], 8'hA5);
    check("tie_rdata0", rdata0, 16'h0FF0);

    // Second tie: port 0 wins again since port 1 was served last
    req0 = 1; rw0 = 1; addr0 = 16'h0010;
    req1 = 1; rw1 = 1; addr1 = 16'h0020;
    run_trace(0, -1, 16'h0);
    check("tie2_done0", done0_tr, 32'h0000_0800);
    check("tie2_done1", done1_tr, 32'h0080_0000);
    check("tie2_grant", grant_tr[1], 0);
    check("tie2_addr", addr_tr[1], 15'h0008);

    // Reset during byte-1 strobe of a write, with a port 1 request queued
    req0 = 1; rw0 = 0; addr0 = 16'h3000; wdata0 = 16'hC3C3;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk100);
      if (c == 0) req0 = 0;
      if (c == 4) begin req1 = 1; rw1 = 1; addr1 = 16'h0100; end
      if (c == 5) req1 = 0;
    end
    check("rstmid_pre_we", we, 0);
    reset = 1'b1;
    #1;
    check("rstmid_we", we, 1);
    check("rstmid_memen", memen, 1);
    check("rstmid_doe", mem_doe, 0);
    check("rstmid_done0", done0, 0);
    @(negedge clk100);
    reset = 1'b0;
    run_trace(0, -1, 16'h0);
    check("rstmid_no_done0", done0_tr, 32'h0);
    check("rstmid_no_done1", done1_tr, 32'h0);
    check("rstmid_idle", busy_tr, 32'h0);
    check("rstmid_memen_hi", memen_tr, 32'hFFFF_FFFF);

    // WAIT_CYCLES=1 read
    req0_w1 = 1; rw0_w1 = 1; addr0_w1 = 16'h0042; mem_hi = 8'h12; mem_lo = 8'h34;
    run_trace(1, -1, 16'h0);
    check("w1_done0", done0_tr, 32'h0000_0080);
    check("w1_dbin", dbin_tr, 32'h0000_0024);
    check("w1_memen", memen_tr, 32'hFFFF_FF81);
    check("w1_rdata0", rdata0_w1, 16'h1234);

    // Port 1 re-requests during its own transaction
    req1 = 1; rw1 = 1; addr1 = 16'h2222; mem_hi = 8'h9C; mem_lo = 8'h3E;
    run_trace(0, 3, 16'h8888);
    check("q_done1", done1_tr, 32'h0080_0800);
    check("q_done0", done0_tr, 32'h0);
    check("q_addr_first", addr_tr[1], 15'h1111);
    check("q_addr_second", addr_tr[13], 15'h4444);
    check("q_grant", grant_tr[13], 1);
    check("q_busy", busy_tr, 32'h007F_E7FE);
    check("q_rdata1", rdata1, 16'h9C3E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
